// File: rtl/addsub_serial_chunk.sv
// Chunk-serial add/sub (ADD/SUB/ADC/SBB) with carry, overflow, zero and negative flags; done pulses NCHUNK edges after start.
// No backpressure: start is taken only in IDLE and ignored while busy; result and flags hold until overwritten.
module addsub_serial_chunk #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx;
  logic             zero_acc;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] s;
  logic             c;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  always_comb begin
    a_chunk = a_r[int'(idx) * CHUNK +: CHUNK];
    b_chunk = b_r[int'(idx) * CHUNK +: CHUNK];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_r};
    s       = sum[CHUNK-1:0];
    c       = sum[CHUNK];
  end

  // Subtraction is a + ~b + c0, so SUB seeds the carry with 1 and SBB with cin.
  always_comb begin
    b_eff = op[0] ? ~b : b;
    case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      default: c0 = cin;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      zero_acc <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b_eff;
            carry_r  <= c0;
            idx      <= '0;
            zero_acc <= 1'b1;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          result[int'(idx) * CHUNK +: CHUNK] <= s;
          carry_r  <= c;
          zero_acc <= zero_acc & (s == '0);
          if (idx == LAST) begin
            cout  <= c;
            zero  <= zero_acc & (s == '0);
            neg   <= s[CHUNK-1];
            // b_r already holds the inverted operand, so this is also correct for subtraction.
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_chunk.sv
// Randomised and directed check of several addsub_serial_chunk configurations against an arithmetic model.
module tb_addsub_serial_chunk;

  localparam int ND = 5;
  localparam int WS[ND] = '{32, 16, 16, 16, 32};
  localparam int NS[ND] = '{4, 16, 4, 1, 1};

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    exp_t        e;
  } dir_t;

  logic        clk, clr_n, start, pstart, start0;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cin;

  logic        bz[ND], dn[ND], cf[ND], ov[ND], zf[ND], ng[ND];
  logic [31:0] rs[ND];
  logic [31:0] r0, r4;
  logic [15:0] r1, r2, r3;

  int vectors = 0;
  int miscompares = 0;

  assign start0 = start | pstart;

  addsub_serial_chunk #(.WIDTH(32), .CHUNK(8)) d0 (
    .clk(clk), .clr_n(clr_n), .start(start0), .op(op), .a(a), .b(b), .cin(cin),
    .busy(bz[0]), .done(dn[0]), .result(r0), .cout(cf[0]), .ovf(ov[0]), .zero(zf[0]), .neg(ng[0]));
  addsub_serial_chunk #(.WIDTH(16), .CHUNK(1)) d1 (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(bz[1]), .done(dn[1]), .result(r1), .cout(cf[1]), .ovf(ov[1]), .zero(zf[1]), .neg(ng[1]));
  addsub_serial_chunk #(.WIDTH(16), .CHUNK(4)) d2 (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(bz[2]), .done(dn[2]), .result(r2), .cout(cf[2]), .ovf(ov[2]), .zero(zf[2]), .neg(ng[2]));
  addsub_serial_chunk #(.WIDTH(16), .CHUNK(16)) d3 (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(bz[3]), .done(dn[3]), .result(r3), .cout(cf[3]), .ovf(ov[3]), .zero(zf[3]), .neg(ng[3]));
  addsub_serial_chunk #(.WIDTH(32), .CHUNK(32)) d4 (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(bz[4]), .done(dn[4]), .result(r4), .cout(cf[4]), .ovf(ov[4]), .zero(zf[4]), .neg(ng[4]));

  assign rs[0] = r0;
  assign rs[1] = {16'h0, r1};
  assign rs[2] = {16'h0, r2};
  assign rs[3] = {16'h0, r3};
  assign rs[4] = r4;

  always #5 clk = ~clk;

  // Whole-word arithmetic: a + (b or ~b) + initial carry, flags read off the wide sum.
  function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] aa,
                                 input logic [31:0] bb, input logic ci);
    exp_t        m;
    logic [31:0] mask;
    logic [32:0] am, be, full;
    logic        c0;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = {1'b0, aa & mask};
    be   = {1'b0, (o[0] ? ~bb : bb) & mask};
    c0   = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : ci;
    full = am + be + {32'h0, c0};
    m.res = full[31:0] & mask;
    m.c   = full[w];
    m.n   = m.res[w-1];
    m.z   = (m.res == 32'h0);
    m.o   = (am[w-1] == be[w-1]) && (m.res[w-1] != am[w-1]);
    return m;
  endfunction

  task automatic chk(input string nm, input int i, input logic [35:0] act, input logic [35:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h required %h", nm, i, act, req);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    for (int i = 0; i < ND; i++) begin
      chk({nm, " busy"}, i, 36'(bz[i]), 36'h0);
      chk({nm, " done"}, i, 36'(dn[i]), 36'h0);
      chk({nm, " result"}, i, 36'(rs[i]), 36'h0);
      chk({nm, " flags"}, i, 36'({cf[i], ov[i], zf[i], ng[i]}), 36'h0);
    end
  endtask

  // Starts an op on every instance and checks done/busy/result each cycle for 16 cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic ci, input bit pert);
    exp_t e[ND];
    for (int i = 0; i < ND; i++) e[i] = model(WS[i], o, aa, bb, ci);
    op = o; a = aa; b = bb; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < ND; i++) begin
        chk("done", i, 36'(dn[i]), 36'(k == NS[i]));
        chk("busy", i, 36'(bz[i]), 36'(k < NS[i]));
        if (k >= NS[i]) begin
          chk("result", i, 36'(rs[i]), 36'(e[i].res));
          chk("cout", i, 36'(cf[i]), 36'(e[i].c));
          chk("ovf", i, 36'(ov[i]), 36'(e[i].o));
          chk("zero", i, 36'(zf[i]), 36'(e[i].z));
          chk("neg", i, 36'(ng[i]), 36'(e[i].n));
        end
      end
      pstart = pert && (k <= 2);
      if (pstart) begin
        a = $urandom; b = $urandom; op = 2'($urandom); cin = 1'($urandom);
      end
    end
    pstart = 1'b0;
  endtask

  dir_t dir[8];

  initial begin
    clk = 0; clr_n = 0; start = 0; pstart = 0; op = 0; a = 0; b = 0; cin = 0;
    //          op     a             b             cin   res           c     o     z     n
    dir[0] = {2'b01, 32'h04444444, 32'h04444444, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    dir[1] = {2'b01, 32'h00000004, 32'h00000002, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
    dir[2] = {2'b01, 32'hFFFFFFF8, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b1};
    dir[3] = {2'b01, 32'hFFFFFFF0, 32'h00000008, 1'b0, 32'hFFFFFFE8, 1'b1, 1'b0, 1'b0, 1'b1};
    dir[4] = {2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    dir[5] = {2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    dir[6] = {2'b10, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    dir[7] = {2'b11, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    clr_n = 1'b1;

    for (int j = 0; j < 8; j++) begin
      chk("model pin", j, 36'(model(32, dir[j].op, dir[j].a, dir[j].b, dir[j].cin)), 36'(dir[j].e));
      run_op(dir[j].op, dir[j].a, dir[j].b, dir[j].cin, 1'b0);
    end

    // Start pulses and operand changes while busy must not disturb the op in flight.
    run_op(2'b01, 32'h4, 32'h2, 1'b0, 1'b1);
    run_op(2'b00, 32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b1);

    // Abort mid-operation at chunk index 2 of the 32/8 instance.
    op = 2'b00; a = 32'h11111111; b = 32'h22222222; cin = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    clr_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) begin
      @(posedge clk); #1;
      chk_all_zero("held in reset");
    end
    clr_n = 1'b1;
    run_op(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      run_op(2'($urandom), $urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_serial_chunk.md
Name: addsub_serial_chunk

Overview:
- Parametrised, multi-cycle adder/subtractor. Successor to the fixed 32-bit combinational subtractor.
- Processes WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, holding the inter-chunk carry in a register.
- Supports ADD, SUB, add-with-carry and subtract-with-borrow, and returns carry, overflow, zero and negative flags.
- Sits beside the datapath ALU as the area-reduced add/sub unit, driven by a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of processing cycles.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
- a  in  WIDTH  operand A, two's complement or unsigned
- b  in  WIDTH  operand B
- cin  in  1  carry input; used by ADC and SBB only
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when result and flags become valid
- result  out  WIDTH  sum or difference
- cout  out  1  carry out of MSB; for subtract, 1 means no borrow
- ovf  out  1  signed overflow
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE, chunk index=0; busy, done, result, cout, ovf, zero and neg all 0. Reset mid-operation abandons the operation with no done pulse.
- Effective operands: b_eff = b for ADD/ADC, ~b for SUB/SBB.
- Initial carry c0: 0 for ADD, 1 for SUB, cin for ADC and SBB. SBB computes a + ~b + cin.
- IDLE, start=1 at edge E0:
  - latch a, b_eff and c0 into internal registers;
  - idx=0, zero_acc=1, busy=1; go to CALC.
- IDLE, start=0: outputs hold their last values; done=0.
- CALC, each edge:
  - {c, s} = a_r[idx chunk] + b_r[idx chunk] + carry_r; write s into result[idx chunk]; carry_r=c;
  - zero_acc &= (s==0);
  - if idx==NCHUNK-1: cout=c; zero=zero_acc & (s==0); neg=s[CHUNK-1]; ovf=(a_r msb==b_r msb) && (s msb != a_r msb); done=1; busy=0; go to IDLE. Otherwise idx++.
- Latency: done is high in the cycle following edge E0+NCHUNK. A new start can be accepted on the same edge that deasserts done, giving back-to-back throughput of one operation per NCHUNK+1 cycles.
- start while busy=1 is ignored. The operands latched at E0 are used; a, b, op and cin may change freely during CALC.
- During CALC, result is partially updated and must not be used until done. Result and flags hold after done until the next accepted start.
- The next accepted start leaves result, cout, ovf, zero and neg unchanged until they are overwritten. Chunks overwrite result progressively; flags update only at the final chunk.
- CHUNK==WIDTH degenerates to a 1-cycle CALC; done follows E0 by one edge.
- ovf compares a_r and b_eff (post-inversion), so SUB overflow is correct.

Test Plan:
- Default params, SUB, a=0x04444444, b=0x04444444 -> result=0x00000000, zero=1, cout=1, ovf=0, neg=0; done exactly 4 edges after the start edge.
- SUB a=4, b=2 -> result=0x00000002, cout=1, flags otherwise 0. Then SUB a=-8 (0xFFFFFFF8), b=-4 -> result=0xFFFFFFFC, neg=1, cout=0, ovf=0.
- SUB a=-16, b=8 -> result=0xFFFFFFE8, neg=1, cout=1, ovf=0. ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1, neg=1, cout=0.
- 64-bit chained add: ADD low words 0xFFFFFFFF+0x00000001 gives result=0, cout=1. Then ADC high words 0+0 with cin=1 gives result=1. SBB a=0, b=0, cin=0 gives 0xFFFFFFFF, cout=0.
- Robustness:
  - start pulsed and operands changed during busy -> ignored; the original result is delivered.
  - clr_n asserted at CALC idx=2 -> all outputs 0 immediately; no done pulse; a subsequent op completes normally.
- Parameter sweep WIDTH=16 CHUNK=1/4/16 and WIDTH=32 CHUNK=32, random a, b, op -> results and flags match a reference model; done latency = NCHUNK edges.
